mm_input_sequencer: RTL and testbench

// - Upstream control stage for logic_top: accepts an external byte stream with valid/ready, buffers it in a small FIFO,
//   and drives input_load_en/valid_input/X_load until xload_done, then holds ALU_en until ALU_done.
// - Then enables the result SRAM (cs_n low) until ry, and reports frame completion or timeout to the host.

---
 rtl/mm_input_sequencer_pkg.sv | 24 ++
 rtl/mm_input_sequencer_sync_byte_fifo.sv | 87 ++++++++
 rtl/mm_input_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_mm_input_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_input_sequencer_pkg.sv
// Shared definitions for the mm_input_sequencer slice.
// - Default widths/depths used by the sequencer and its input FIFO.
// - Sequencer state encoding (3-bit, IDLE=0 .. DONE=4).
// - Helper that classifies the states supervised by the wait counter.
package mm_input_sequencer_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int TIMEOUT_DEF    = 1023;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_READ    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // States in which the sequencer waits on logic_top and the timeout runs.
    function automatic logic is_wait_state(input state_t st);
        return (st == ST_LOAD) || (st == ST_COMPUTE) || (st == ST_READ);
    endfunction

endpackage

// File: rtl/mm_input_sequencer_sync_byte_fifo.sv
// sync_byte_fifo: small synchronous FIFO with a registered read port.
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset (empties FIFO)
//   push, din      write request and data; accepted when not full or when a pop
//                  happens in the same cycle
//   pop            read request; ignored when empty
//   dout           registered head byte, updated only on an accepted pop, so it
//                  holds the last popped value otherwise
//   full, empty    occupancy flags
module sync_byte_fifo
    import mm_input_sequencer_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] dout_r;
    logic              full_s;
    logic              empty_s;
    logic              pop_ok_s;
    logic              push_ok_s;

    assign full_s    = (count_r == DEPTH_CNT);
    assign empty_s   = (count_r == CNT_ZERO);
    assign pop_ok_s  = pop && !empty_s;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a byte.
    assign push_ok_s = push && (!full_s || pop_ok_s);

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers (wrap naturally, depth is a power of two), occupancy and read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
            dout_r   <= {DATA_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                dout_r   <= mem_r[rd_ptr_r];
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = dout_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/mm_input_sequencer.sv
// mm_input_sequencer: upstream control stage for logic_top.
// Buffers a host byte stream in a small FIFO, then for each frame started by the
// host: streams bytes to logic_top (LOAD) until xload_done, holds ALU_en until
// ALU_done (COMPUTE), selects the result SRAM until ry (READ), and pulses
// frame_done (DONE). A wait counter aborts any stalled wait state after TIMEOUT
// cycles and raises the sticky timeout_err.
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   start                         host frame request (only honoured in IDLE)
//   in_data, in_valid, in_ready   host byte stream, transfer on in_valid & in_ready
//   xload_done, ALU_done, ry      progress handshakes from logic_top
//   input_load_en, valid_input,
//   X_load, ALU_en, cs_n          registered controls to logic_top
//   busy, frame_done, timeout_err registered host status
// All registered outputs are computed from the next state, so they change on the
// same edge as the state they belong to, one cycle after the causing input.
module mm_input_sequencer
    import mm_input_sequencer_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              xload_done,
    input  logic              ALU_done,
    input  logic              ry,
    output logic              input_load_en,
    output logic              valid_input,
    output logic [DATA_W-1:0] X_load,
    output logic              ALU_en,
    output logic              cs_n,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // The abort fires on the cycle whose increment would make the count reach TIMEOUT,
    // so a wait state lasts at most TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic [CNT_W-1:0]  wait_cnt_next_s;
    logic              wait_expired_s;
    logic              pop_s;
    logic              abort_s;
    logic              clr_err_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    logic              input_load_en_r;
    logic              valid_input_r;
    logic              alu_en_r;
    logic              cs_n_r;
    logic              busy_r;
    logic              frame_done_r;
    logic              timeout_err_r;

    sync_byte_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .din   (in_data),
        .pop   (pop_s),
        .dout  (X_load),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign in_ready       = !fifo_full_s || pop_s;
    assign wait_expired_s = (wait_cnt_r == CNT_LAST);

    // Next-state, FIFO pop and error set/clear decisions.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        abort_s      = 1'b0;
        clr_err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_LOAD;
                    clr_err_s    = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // A byte popped in the same cycle as xload_done is still presented;
                // anything left in the FIFO waits for the next frame.
                pop_s = !fifo_empty_s;
                if (xload_done) begin
                    next_state_s = ST_COMPUTE;
                end else if (!pop_s && wait_expired_s) begin
                    next_state_s = ST_IDLE;
                    abort_s      = 1'b1;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_COMPUTE: begin
                if (ALU_done) begin
                    next_state_s = ST_READ;
                end else if (wait_expired_s) begin
                    next_state_s = ST_IDLE;
                    abort_s      = 1'b1;
                end else begin
                    next_state_s = ST_COMPUTE;
                end
            end
            ST_READ: begin
                if (ry) begin
                    next_state_s = ST_DONE;
                end else if (wait_expired_s) begin
                    next_state_s = ST_IDLE;
                    abort_s      = 1'b1;
                end else begin
                    next_state_s = ST_READ;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Wait counter: restarts on state entry and on every byte moved in LOAD.
    always_comb begin
        if (next_state_s != state_r) begin
            wait_cnt_next_s = CNT_ZERO;
        end else if (pop_s) begin
            wait_cnt_next_s = CNT_ZERO;
        end else if (is_wait_state(state_r)) begin
            wait_cnt_next_s = wait_cnt_r + CNT_ONE;
        end else begin
            wait_cnt_next_s = CNT_ZERO;
        end
    end

    // State, wait counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            wait_cnt_r      <= CNT_ZERO;
            input_load_en_r <= 1'b0;
            valid_input_r   <= 1'b0;
            alu_en_r        <= 1'b0;
            cs_n_r          <= 1'b1;
            busy_r          <= 1'b0;
            frame_done_r    <= 1'b0;
            timeout_err_r   <= 1'b0;
        end else begin
            state_r         <= next_state_s;
            wait_cnt_r      <= wait_cnt_next_s;
            input_load_en_r <= (next_state_s == ST_LOAD);
            valid_input_r   <= pop_s;
            alu_en_r        <= (next_state_s == ST_COMPUTE);
            cs_n_r          <= (next_state_s != ST_READ);
            busy_r          <= (next_state_s != ST_IDLE);
            frame_done_r    <= (next_state_s == ST_DONE);
            if (abort_s) begin
                timeout_err_r <= 1'b1;
            end else if (clr_err_s) begin
                timeout_err_r <= 1'b0;
            end
        end
    end

    assign input_load_en = input_load_en_r;
    assign valid_input   = valid_input_r;
    assign ALU_en        = alu_en_r;
    assign cs_n          = cs_n_r;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;
    assign timeout_err   = timeout_err_r;

endmodule

// File: tb/tb_mm_input_sequencer.sv
// Self-checking bench for mm_input_sequencer (DATA_W=8, FIFO_DEPTH=4, TIMEOUT=15).
// A producer process feeds bytes from send_q with valid/ready; every accepted byte
// is pushed onto exp_q and each valid_input strobe must present the queue head.
module tb_mm_input_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       xload_done;
    logic       ALU_done;
    logic       ry;
    logic       input_load_en;
    logic       valid_input;
    logic [7:0] X_load;
    logic       ALU_en;
    logic       cs_n;
    logic       busy;
    logic       frame_done;
    logic       timeout_err;

    logic [7:0] send_q[$];
    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_errors;
    int         fd_cnt;
    int         frames_done;

    mm_input_sequencer #(
        .DATA_W     (8),
        .FIFO_DEPTH (4),
        .TIMEOUT    (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .xload_done    (xload_done),
        .ALU_done      (ALU_done),
        .ry            (ry),
        .input_load_en (input_load_en),
        .valid_input   (valid_input),
        .X_load        (X_load),
        .ALU_en        (ALU_en),
        .cs_n          (cs_n),
        .busy          (busy),
        .frame_done    (frame_done),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Producer: presents send_q head, records accepted bytes as expected X_load values.
    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                send_q.delete(0);
            end
            #1;
            if (send_q.size() != 0) begin
                in_valid = 1'b1;
                in_data  = send_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'h00;
            end
        end
    end

    // Scoreboard: every strobe must carry the oldest accepted byte.
    always @(negedge clk) begin
        if (valid_input) begin
            if (exp_q.size() == 0) begin
                check("x_load_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                check("x_load", {24'd0, X_load}, {24'd0, exp_q.pop_front()});
            end
        end
        if (frame_done) begin
            fd_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_in_ready"},      {31'd0, in_ready},      32'd1);
        check({pfx, "_busy"},          {31'd0, busy},          32'd0);
        check({pfx, "_input_load_en"}, {31'd0, input_load_en}, 32'd0);
        check({pfx, "_valid_input"},   {31'd0, valid_input},   32'd0);
        check({pfx, "_x_load"},        {24'd0, X_load},        32'd0);
        check({pfx, "_alu_en"},        {31'd0, ALU_en},        32'd0);
        check({pfx, "_cs_n"},          {31'd0, cs_n},          32'd1);
        check({pfx, "_frame_done"},    {31'd0, frame_done},    32'd0);
        check({pfx, "_timeout_err"},   {31'd0, timeout_err},   32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        send_q.push_back(b);
    endtask

    // Wait until the producer has handed every queued byte to the FIFO.
    task automatic wait_sent();
        int g;
        g = 0;
        while (send_q.size() != 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("send_drained", send_q.size(), 32'd0);
        @(negedge clk);
    endtask

    // One frame, driven at negedges. n_strobe bytes are expected in LOAD; with
    // early_xld, xload_done coincides with the pop of the last of them. With no_alu
    // the task returns in COMPUTE without ever raising ALU_done.
    task automatic run_frame(input int n_strobe, input bit early_xld, input bit poke_busy,
                             input bit poke_done, input bit no_alu);
        int seen;
        int guard;
        int target;
        target = early_xld ? n_strobe - 1 : n_strobe;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("frame_busy", {31'd0, busy}, 32'd1);
        check("frame_load_en", {31'd0, input_load_en}, 32'd1);
        check("frame_err_cleared", {31'd0, timeout_err}, 32'd0);
        seen  = 0;
        guard = 0;
        forever begin
            if (valid_input) seen++;
            if (seen >= target) break;
            guard++;
            if (guard > 60) begin
                check("strobe_wait_expired", seen, target);
                break;
            end
            @(negedge clk);
        end
        xload_done = 1'b1;
        @(negedge clk);
        xload_done = 1'b0;
        if (valid_input) seen++;
        check("load_closed", {31'd0, input_load_en}, 32'd0);
        check("alu_en_on", {31'd0, ALU_en}, 32'd1);
        check("strobe_count", seen, n_strobe);
        if (!no_alu) begin
            repeat (2) begin
                if (poke_busy) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("compute_alu_en", {31'd0, ALU_en}, 32'd1);
                check("compute_busy", {31'd0, busy}, 32'd1);
            end
            ALU_done = 1'b1;
            @(negedge clk);
            ALU_done = 1'b0;
            check("read_alu_en_off", {31'd0, ALU_en}, 32'd0);
            check("read_cs_n", {31'd0, cs_n}, 32'd0);
            @(negedge clk);
            check("read_cs_n_held", {31'd0, cs_n}, 32'd0);
            ry = 1'b1;
            @(negedge clk);
            ry = 1'b0;
            check("done_cs_n", {31'd0, cs_n}, 32'd1);
            check("done_pulse", {31'd0, frame_done}, 32'd1);
            if (poke_done) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("done_pulse_end", {31'd0, frame_done}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
            check("idle_busy_hold", {31'd0, busy}, 32'd0);
            frames_done++;
        end
    endtask

    initial begin
        int alu_cycles;
        n_checks    = 0;
        n_errors    = 0;
        fd_cnt      = 0;
        frames_done = 0;
        rst         = 1'b1;
        start       = 1'b0;
        xload_done  = 1'b0;
        ALU_done    = 1'b0;
        ry          = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;
        @(negedge clk);

        // Nominal frame, with start poked while busy and in the DONE cycle.
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_sent();
        run_frame(4, 1'b0, 1'b1, 1'b1, 1'b0);

        // Backpressure: six bytes into a four-deep FIFO with no frame running.
        for (int i = 1; i <= 6; i++) send(8'hA0 + 8'(i));
        repeat (8) @(negedge clk);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_pending", send_q.size(), 32'd2);
        run_frame(6, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_all_sent", send_q.size(), 32'd0);

        // xload_done coincident with the third pop; the fourth byte waits.
        send(8'h5A); send(8'h6B); send(8'h7C); send(8'h8D);
        wait_sent();
        run_frame(3, 1'b1, 1'b0, 1'b0, 1'b0);
        check("simul_leftover", exp_q.size(), 32'd1);
        send(8'h9E);
        wait_sent();
        run_frame(2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Compute timeout: ALU_done never arrives.
        run_frame(0, 1'b0, 1'b0, 1'b0, 1'b1);
        alu_cycles = 1;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (!ALU_en) break;
            alu_cycles++;
        end
        check("to_alu_cycles", alu_cycles, 32'd15);
        check("to_err", {31'd0, timeout_err}, 32'd1);
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_cs_n", {31'd0, cs_n}, 32'd1);
        check("to_load_en", {31'd0, input_load_en}, 32'd0);
        repeat (2) @(negedge clk);
        check("to_err_sticky", {31'd0, timeout_err}, 32'd1);
        send(8'h3C);
        wait_sent();
        run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("frames_so_far", fd_cnt, frames_done);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        // Reset mid-LOAD discards the frame and the buffered bytes.
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
        wait_sent();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 10; g++) begin
            if (valid_input) break;
            @(negedge clk);
        end
        check("pre_reset_strobe", {31'd0, valid_input}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_after");
        send(8'hE7);
        wait_sent();
        run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("frame_done_total", fd_cnt, frames_done);
        check("frames_expected", frames_done, 32'd6);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
